// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Takes the EX/MEM ALU result as a byte address, drives a req/ready/rvalid
// data bus with byte lanes, extends load data, and stalls the pipeline until
// the access completes or times out.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word accesses skip the bus and report misaligned with mem_done.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        start;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic        mis_in;
    logic [7:0]  cnt;
    logic        cnt_last;
    logic        is_load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    // Sign/zero-extend the addressed byte or halfword of a read word.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'd0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'd0, h};
            default: extend_load = word;
        endcase
    endfunction

    // Reset is gated in so nothing is reported as stalling while reset is held.
    assign start    = ~rst & (state == IDLE) & ex_mem_valid & ~flush & (mem_read | mem_write);
    assign cnt_last = (cnt == LAST_CNT);

    assign dmem_req  = (state == REQ);
    assign dmem_we   = (state == REQ) & ~is_load_q;
    assign mem_stall = start | (state == REQ) | (state == RESP);
    assign mem_done  = (state == DONE);

    // Decode funct3 into byte enables, lane-replicated write data and the misalignment flag.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; a missing default would infer a latch.
        be_in    = 4'b1111;
        wdata_in = store_data;
        mis_in   = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << alu_result[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_in    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
            end
            default: ;
        endcase
`ifdef MISALIGN_TRAP_EN
        mis_in = ((funct3[1:0] == 2'b01) & alu_result[0]) | (funct3[1] & (|alu_result[1:0]));
`endif
        if (mem_read) begin
            be_in    = 4'b1111;
            wdata_in = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block evaluation order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: bus handshake progress and timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = mis_in ? DONE : REQ;
            REQ: begin
                if (dmem_ready)    state_next = is_load_q ? RESP : DONE;
                else if (cnt_last) state_next = DONE;
            end
            RESP: if (dmem_rvalid || cnt_last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timeout counter: cleared on entry to REQ/RESP, counts while waiting there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state_next == REQ && state != REQ) || (state_next == RESP && state != RESP)) begin
            cnt <= '0;
        end else if (state == REQ || state == RESP) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Capture the access at start, and record the result status as the access ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            is_load_q  <= 1'b0;
            load_data  <= '0;
            bus_err    <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_addr  <= {alu_result[31:2], 2'b00};
                        dmem_wdata <= wdata_in;
                        dmem_be    <= be_in;
                        funct3_q   <= funct3;
                        off_q      <= alu_result[1:0];
                        is_load_q  <= mem_read;
                        bus_err    <= 1'b0;
                        misaligned <= mis_in;
                        if (mis_in) load_data <= '0;
                    end
                end
                REQ: begin
                    if (!dmem_ready && cnt_last) begin
                        bus_err   <= 1'b1;
                        load_data <= '0;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        load_data <= extend_load(dmem_rdata, funct3_q, off_q);
                    end else if (cnt_last) begin
                        bus_err   <= 1'b1;
                        load_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute stage. Consumes the EX/MEM-registered ALU result as the address, the forwarded rs2 value as store data, and funct3 as the access size. Drives a req/ready/rvalid data-memory bus, builds byte lanes and sign/zero-extends loads. Stalls the pipeline via the hazard unit until the access completes or times out.

Parameters:
TIMEOUT, 16, cycles to wait for dmem_ready or dmem_rvalid before aborting; 1..255.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
ex_mem_valid  input  1  EX/MEM register holds a valid instruction
flush  input  1  kill the instruction in EX/MEM; blocks a new access start only
mem_read  input  1  load instruction
mem_write  input  1  store instruction
funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result  input  32  byte address
store_data  input  32  forwarded rs2 value
dmem_req  output  1  bus request
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ready  input  1  request accepted this cycle
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read word
mem_stall  output  1  freeze IF..EX/MEM registers
mem_done  output  1  one-cycle pulse; access result valid
load_data  output  32  extended load result to MEM/WB
bus_err  output  1  access aborted by timeout; valid with mem_done
misaligned  output  1  misaligned access; valid with mem_done

Behaviour:
- Reset (async): state IDLE; dmem_req, dmem_we, mem_stall, mem_done, bus_err and misaligned are 0; dmem_addr, dmem_wdata, dmem_be and load_data are 0.
- States: IDLE, REQ, RESP, DONE.
- Start condition: IDLE & ex_mem_valid & ~flush & (mem_read | mem_write). mem_read has priority if both are set.
- In the start cycle, mem_stall = 1 combinationally. Address, data, be, funct3 and access type are captured. Next state is REQ.
- REQ: dmem_req = 1 with stable registered bus outputs.
  - dmem_ready & store -> DONE.
  - dmem_ready & load -> RESP.
  - dmem_rvalid is ignored in REQ.
- RESP: wait for dmem_rvalid, capture extended rdata into load_data, then -> DONE.
- DONE: mem_stall = 0 and mem_done = 1 for exactly one cycle, then -> IDLE. Inputs seen in DONE never restart an access.
- mem_stall = 1 in REQ and RESP, and in IDLE only when the start condition holds. Non-memory instructions never stall and never pulse mem_done.
- Timeout: an 8-bit counter clears on entry to REQ and to RESP and increments each cycle in those states. At count == TIMEOUT-1 without the awaited signal: -> DONE with bus_err = 1 and load_data = 0, and dmem_req drops.
- flush does not cancel an in-flight access. Once REQ is entered, the bus transaction runs to completion or timeout.
- Store lanes:
  - SB: be = 0001<<a[1:0], wdata = {4{d[7:0]}}.
  - SH: be = 0011<<(2*a[1]), wdata = {2{d[15:0]}}.
  - SW: be = 1111, wdata = d.
- Load lanes: byte selected by a[1:0], half selected by a[1]. B/H sign-extend, BU/HU zero-extend, W passes through.
- funct3 011, 110 and 111 are treated as W.
- Loads drive dmem_be = 1111 and dmem_wdata = 0.
- bus_err, misaligned and load_data hold their values until the next access start, which clears bus_err and misaligned.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: an access is misaligned if it is H/HU with a[0] = 1, or W with a[1:0] != 0. A misaligned access issues no bus request; the start cycle goes directly to DONE with misaligned = 1 and load_data = 0 (stall for 1 cycle).
- Undefined: misaligned is tied to 0. Offending low address bits are ignored: H uses a[1] only, W ignores a[1:0]. The access proceeds normally.

Test Plan:
- SB store_data=0x000000A5, alu_result=0x103, dmem_ready on the 1st REQ cycle -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100, mem_stall high for 2 cycles, then mem_done pulse.
- LB alu_result=0x202, rdata=0x12F03456, rvalid 3 cycles after ready -> load_data=0xFFFFFFF0; the same access as LBU -> 0x000000F0.
- LH alu_result=0x0 with rdata=0x8001ABCD -> load_data=0xFFFFABCD; LHU at 0x2 -> 0x00008001.
- TIMEOUT=16, load with dmem_ready held low -> dmem_req drops after 16 REQ cycles, bus_err=1, load_data=0, mem_done pulse, state returns to IDLE.
- flush=1 with a valid store -> no dmem_req, no stall. flush raised during REQ -> the access still completes. rst asserted mid-RESP -> all outputs 0 immediately.
- With MISALIGN_TRAP_EN, SW at 0x101 -> no dmem_req, misaligned=1 with mem_done the next cycle. Without it -> be=1111, addr=0x100, misaligned=0.
